// File: rtl/flash_debug_stats_if.sv
// flash_debug_stats_if: command events, live bus snapshots, VIO control and probe outputs.
interface flash_debug_stats_if;
  logic        cmd_issue;
  logic        cmd_done;
  logic        ecc_err;
  logic [15:0] raw_data;
  logic [15:0] bus_state;
  logic [15:0] ctrl_state;
  logic [63:0] ctl_word;
  logic [15:0] dbg_0;
  logic [15:0] dbg_1;
  logic [15:0] dbg_2;
  logic [15:0] dbg_3;
  logic [15:0] dbg_4;
  logic [63:0] dbg_5_64;
  logic [63:0] dbg_6_64;
  logic [63:0] status_word;
  modport master (
    output cmd_issue, cmd_done, ecc_err, raw_data, bus_state, ctrl_state, ctl_word,
    input  dbg_0, dbg_1, dbg_2, dbg_3, dbg_4, dbg_5_64, dbg_6_64, status_word
  );
  modport slave (
    input  cmd_issue, cmd_done, ecc_err, raw_data, bus_state, ctrl_state, ctl_word,
    output dbg_0, dbg_1, dbg_2, dbg_3, dbg_4, dbg_5_64, dbg_6_64, status_word
  );
endinterface

// File: rtl/flash_debug_stats.sv
// flash_debug_stats: flash command latency / error statistics for ILA/VIO probes.
// Define DEBUG_STATS_MAXLAT_EN to track the maximum recorded latency in status_word[63:32].
module flash_debug_stats #(
  parameter int unsigned TIMEOUT = 1000000
) (
  input logic                v_clk0,
  input logic                v_rst0,
  flash_debug_stats_if.slave bus
);
  localparam logic [0:0] IDLE = 1'b0, BUSY = 1'b1;
  logic [0:0]  state_q, state_d;
  logic [31:0] cur_lat_q, cur_lat_d, last_lat_q, last_lat_d, ecc_cnt_q, ecc_cnt_d, max_lat_d;
  logic [15:0] cmd_cnt_q, cmd_cnt_d, ovl_cnt_q, ovl_cnt_d, spur_cnt_q, spur_cnt_d, tmo_cnt_q, tmo_cnt_d;
  logic [63:0] lat_sum_q, lat_sum_d;
  logic        clr_prev_q, clr, freeze, busy, done_ok, tmo, ovl, spur, start, upd, unused_ctl;
  assign unused_ctl = ^bus.ctl_word[63:2];
  always_comb begin
    busy = state_q == BUSY;
    clr = bus.ctl_word[0] & ~clr_prev_q;
    freeze = bus.ctl_word[1];
    upd = ~freeze | clr;
    done_ok = busy & bus.cmd_done;
    tmo = busy & ~bus.cmd_done & (cur_lat_q == TIMEOUT);
    ovl = busy & bus.cmd_issue & ~bus.cmd_done;
    spur = ~busy & bus.cmd_done;
    start = bus.cmd_issue & (~busy | bus.cmd_done);
    state_d = start ? BUSY : (done_ok | tmo) ? IDLE : state_q;
    cur_lat_d = start ? 32'd1 : (busy & ~done_ok & ~tmo & ~&cur_lat_q) ? cur_lat_q + 32'd1 : cur_lat_q;
    cmd_cnt_d = clr ? '0 : cmd_cnt_q + 16'(done_ok);
    lat_sum_d = clr ? '0 : lat_sum_q + (done_ok ? 64'(cur_lat_q) : 64'd0);
    last_lat_d = clr ? '0 : done_ok ? cur_lat_q : last_lat_q;
    ovl_cnt_d = clr ? '0 : ovl_cnt_q + 16'(ovl & ~&ovl_cnt_q);
    spur_cnt_d = clr ? '0 : spur_cnt_q + 16'(spur & ~&spur_cnt_q);
    tmo_cnt_d = clr ? '0 : tmo_cnt_q + 16'(tmo & ~&tmo_cnt_q);
    ecc_cnt_d = clr ? '0 : ecc_cnt_q + 32'(bus.ecc_err & ~&ecc_cnt_q);
  end
`ifdef DEBUG_STATS_MAXLAT_EN
  logic [31:0] max_lat_q;
  assign max_lat_d = clr ? '0 : (done_ok && cur_lat_q > max_lat_q) ? cur_lat_q : max_lat_q;
  always_ff @(posedge v_clk0 or negedge v_rst0)
    if (!v_rst0) max_lat_q <= '0;
    else max_lat_q <= max_lat_d;
`else
  assign max_lat_d = '0;
`endif
  always_ff @(posedge v_clk0 or negedge v_rst0) begin
    if (!v_rst0) begin
      state_q <= IDLE;
      cur_lat_q <= '0;
      last_lat_q <= '0;
      ecc_cnt_q <= '0;
      cmd_cnt_q <= '0;
      ovl_cnt_q <= '0;
      spur_cnt_q <= '0;
      tmo_cnt_q <= '0;
      lat_sum_q <= '0;
      clr_prev_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_lat_q <= cur_lat_d;
      last_lat_q <= last_lat_d;
      ecc_cnt_q <= ecc_cnt_d;
      cmd_cnt_q <= cmd_cnt_d;
      ovl_cnt_q <= ovl_cnt_d;
      spur_cnt_q <= spur_cnt_d;
      tmo_cnt_q <= tmo_cnt_d;
      lat_sum_q <= lat_sum_d;
      clr_prev_q <= bus.ctl_word[0];
    end
  end
  // Outputs load next-state values so they follow their cause by exactly one cycle.
  always_ff @(posedge v_clk0 or negedge v_rst0) begin
    if (!v_rst0) begin
      bus.dbg_0 <= '0;
      bus.dbg_1 <= '0;
      bus.dbg_2 <= '0;
      bus.dbg_3 <= '0;
      bus.dbg_4 <= '0;
      bus.dbg_5_64 <= '0;
      bus.dbg_6_64 <= '0;
      bus.status_word <= '0;
    end else begin
      bus.status_word[15:0] <= {14'b0, freeze, state_d == BUSY};
      if (upd) begin
        bus.dbg_0 <= bus.raw_data;
        bus.dbg_1 <= bus.bus_state;
        bus.dbg_2 <= bus.ctrl_state;
        bus.dbg_3 <= |last_lat_d[31:16] ? 16'hFFFF : last_lat_d[15:0];
        bus.dbg_4 <= cmd_cnt_d;
        bus.dbg_5_64 <= lat_sum_d;
        bus.dbg_6_64 <= {tmo_cnt_d, ovl_cnt_d, ecc_cnt_d};
        bus.status_word[63:16] <= {max_lat_d, spur_cnt_d};
      end
    end
  end
endmodule
